// File: rtl/ysnp_pkg.sv
// rtl/ysnp_pkg.sv - shared state and mode types for the password-lock controller
package ysnp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        EVAL,
        RESULT,
        LOCKOUT
    } state_t;

    typedef enum logic {
        MODE_ENTER,
        MODE_CREATE
    } mode_t;

endpackage

// File: rtl/ysnp_edge_det.sv
// rtl/ysnp_edge_det.sv - registers a level input and emits a one-cycle rising-edge pulse
module ysnp_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/ysnp_lock_ctrl.sv
// rtl/ysnp_lock_ctrl.sv - password-lock controller with guarded re-program and timed lockout
module ysnp_lock_ctrl
    import ysnp_pkg::*;
#(
    parameter int DIGITS      = 3,
    parameter int DW          = 3,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1024
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [DW-1:0]                  D,
    input  logic                           EN,
    input  logic                           create,
    output logic                           open,
    output logic                           nope,
    output logic                           locked,
    output logic                           pass_set,
    output logic [DIGITS-1:0]              LEDS,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

    localparam int FW  = $clog2(MAX_FAILS + 1);
    localparam int IW  = $clog2(DIGITS + 1);
    localparam int LCW = $clog2(LOCKOUT_CYC);

    state_t                     state;
    state_t                     next_state;
    mode_t                      mode;
    logic [IW-1:0]              idx;
    logic [DIGITS-1:0][DW-1:0]  entry_buf;
    logic [DIGITS-1:0][DW-1:0]  code;
    logic                       prev_open;
    logic [LCW-1:0]             lock_cnt;

    logic                       press;
    logic                       abort;
    logic                       last_digit;
    logic                       code_match;
    logic                       create_ok;
    logic [FW-1:0]              fail_inc;
    logic                       lock_trip;
    logic                       lock_done;

    ysnp_edge_det u_en_edge (
        .clk   (CLK),
        .rst_n (RST_N),
        .level (EN),
        .pulse (press)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, RESULT: begin
                if (press) begin
                    next_state = (DIGITS == 1) ? EVAL : ENTRY;
                end
            end
            ENTRY: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (press && last_digit) begin
                    next_state = EVAL;
                end
            end
            EVAL:    next_state = lock_trip ? LOCKOUT : RESULT;
            LOCKOUT: begin
                if (lock_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Decisions feeding the registered outputs; only meaningful in the state that uses them.
    always_comb begin
        abort      = (state == ENTRY) && (mode_t'(create) != mode);
        last_digit = (idx == IW'(DIGITS - 1));
        code_match = (entry_buf == code);
        create_ok  = !pass_set || prev_open;
        fail_inc   = fail_cnt + FW'(1);
        lock_trip  = (state == EVAL) && (mode == MODE_ENTER) && pass_set &&
                     !code_match && (fail_inc == FW'(MAX_FAILS));
        lock_done  = (state == LOCKOUT) && (lock_cnt == LCW'(LOCKOUT_CYC - 1));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode      <= MODE_ENTER;
            idx       <= '0;
            entry_buf <= '0;
            code      <= '0;
            prev_open <= 1'b0;
            lock_cnt  <= '0;
            open      <= 1'b0;
            nope      <= 1'b0;
            locked    <= 1'b0;
            pass_set  <= 1'b0;
            LEDS      <= '0;
            fail_cnt  <= '0;
        end else begin
            case (state)
                IDLE, RESULT: begin
                    if (press) begin
                        entry_buf[0] <= D;
                        mode         <= mode_t'(create);
                        idx          <= IW'(1);
                        LEDS         <= DIGITS'(1);
                        open         <= 1'b0;
                        nope         <= 1'b0;
                    end
                end
                ENTRY: begin
                    if (abort) begin
                        entry_buf <= '0;
                        LEDS      <= '0;
                        idx       <= '0;
                    end else if (press) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (i == int'(idx)) begin
                                entry_buf[i] <= D;
                                LEDS[i]      <= 1'b1;
                            end
                        end
                        idx <= idx + IW'(1);
                    end
                end
                EVAL: begin
                    if (mode == MODE_CREATE) begin
                        if (create_ok) begin
                            code      <= entry_buf;
                            pass_set  <= 1'b1;
                            open      <= 1'b1;
                            prev_open <= 1'b1;
                        end else begin
                            nope      <= 1'b1;
                            prev_open <= 1'b0;
                        end
                    end else if (!pass_set) begin
                        nope      <= 1'b1;
                        prev_open <= 1'b0;
                    end else if (code_match) begin
                        open      <= 1'b1;
                        prev_open <= 1'b1;
                        fail_cnt  <= '0;
                    end else begin
                        nope      <= 1'b1;
                        prev_open <= 1'b0;
                        fail_cnt  <= fail_inc;
                    end
                    if (lock_trip) begin
                        locked   <= 1'b1;
                        LEDS     <= '0;
                        lock_cnt <= '0;
                    end
                end
                LOCKOUT: begin
                    lock_cnt <= lock_cnt + LCW'(1);
                    if (lock_done) begin
                        locked   <= 1'b0;
                        nope     <= 1'b0;
                        fail_cnt <= '0;
                        LEDS     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysnp_lock_ctrl.sv
// tb/tb_ysnp_lock_ctrl.sv - directed self-checking bench for ysnp_lock_ctrl
module tb_ysnp_lock_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [2:0] D;
    logic       EN;
    logic       create;
    logic       open;
    logic       nope;
    logic       locked;
    logic       pass_set;
    logic [2:0] LEDS;
    logic [1:0] fail_cnt;

    int passed = 0;
    int total  = 0;

    ysnp_lock_ctrl #(
        .DIGITS      (3),
        .DW          (3),
        .MAX_FAILS   (3),
        .LOCKOUT_CYC (8)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .D        (D),
        .EN       (EN),
        .create   (create),
        .open     (open),
        .nope     (nope),
        .locked   (locked),
        .pass_set (pass_set),
        .LEDS     (LEDS),
        .fail_cnt (fail_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic press(input logic [2:0] d);
        @(negedge CLK);
        D  = d;
        EN = 1'b1;
        @(negedge CLK);
        EN = 1'b0;
    endtask

    task automatic attempt(input logic cr, input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2);
        create = cr;
        press(d0);
        press(d1);
        press(d2);
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST_N = 1'b0; EN = 1'b0; create = 1'b0; D = 3'd0;
        #12;
        total++;
        if ({open, nope, locked, pass_set, LEDS, fail_cnt} !== 9'd0)
            $display("FAIL reset_outputs got=%b want=0", {open, nope, locked, pass_set, LEDS, fail_cnt});
        else passed++;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_create;
        create = 1'b1;
        press(3'd5);
        total++; if (LEDS !== 3'b001) $display("FAIL create_leds0 got=%b want=001", LEDS); else passed++;
        press(3'd2);
        total++; if (LEDS !== 3'b011) $display("FAIL create_leds1 got=%b want=011", LEDS); else passed++;
        press(3'd7);
        total++; if (LEDS !== 3'b111) $display("FAIL create_leds2 got=%b want=111", LEDS); else passed++;
        total++; if (open !== 1'b0) $display("FAIL create_open_early got=%b want=0", open); else passed++;
        @(negedge CLK);
        total++; if ({open, nope, pass_set} !== 3'b101)
            $display("FAIL create_result got=%b want=101", {open, nope, pass_set}); else passed++;
    endtask

    task automatic test_enter;
        attempt(1'b0, 3'd5, 3'd2, 3'd7);
        total++; if ({open, nope, fail_cnt} !== 4'b1000)
            $display("FAIL enter_match got=%b want=1000", {open, nope, fail_cnt}); else passed++;
        attempt(1'b0, 3'd5, 3'd2, 3'd6);
        total++; if ({open, nope, fail_cnt} !== 4'b0101)
            $display("FAIL enter_mismatch got=%b want=0101", {open, nope, fail_cnt}); else passed++;
    endtask

    task automatic test_lockout;
        attempt(1'b0, 3'd5, 3'd2, 3'd7);
        attempt(1'b0, 3'd5, 3'd2, 3'd6);
        attempt(1'b0, 3'd5, 3'd2, 3'd6);
        total++; if ({locked, fail_cnt} !== 3'b010)
            $display("FAIL lock_two_fails got=%b want=010", {locked, fail_cnt}); else passed++;
        attempt(1'b0, 3'd5, 3'd2, 3'd6);
        total++; if ({locked, nope, fail_cnt} !== 4'b1111)
            $display("FAIL lock_enter got=%b want=1111", {locked, nope, fail_cnt}); else passed++;
        for (int k = 0; k < 8; k++) begin
            total++;
            if ({locked, LEDS} !== 4'b1000)
                $display("FAIL lock_hold cyc=%0d got=%b want=1000", k, {locked, LEDS});
            else passed++;
            D  = 3'd5;
            EN = (k % 2 == 0);
            @(negedge CLK);
        end
        EN = 1'b0;
        total++; if ({locked, nope, fail_cnt, LEDS} !== 7'd0)
            $display("FAIL lock_exit got=%b want=0", {locked, nope, fail_cnt, LEDS}); else passed++;
        attempt(1'b0, 3'd5, 3'd2, 3'd7);
        total++; if (open !== 1'b1) $display("FAIL lock_after_open got=%b want=1", open); else passed++;
    endtask

    task automatic test_guarded_create;
        attempt(1'b0, 3'd5, 3'd2, 3'd6);
        attempt(1'b1, 3'd1, 3'd1, 3'd1);
        total++; if ({open, nope, fail_cnt} !== 4'b0101)
            $display("FAIL create_refused got=%b want=0101", {open, nope, fail_cnt}); else passed++;
        attempt(1'b0, 3'd5, 3'd2, 3'd7);
        total++; if (open !== 1'b1) $display("FAIL code_kept got=%b want=1", open); else passed++;
        attempt(1'b1, 3'd1, 3'd1, 3'd1);
        total++; if ({open, nope} !== 2'b10) $display("FAIL create_allowed got=%b want=10", {open, nope}); else passed++;
        attempt(1'b0, 3'd1, 3'd1, 3'd1);
        total++; if (open !== 1'b1) $display("FAIL new_code_open got=%b want=1", open); else passed++;
        attempt(1'b0, 3'd5, 3'd2, 3'd7);
        total++; if ({nope, fail_cnt} !== 3'b101)
            $display("FAIL old_code_rejected got=%b want=101", {nope, fail_cnt}); else passed++;
    endtask

    task automatic test_abort_and_hold;
        create = 1'b0;
        press(3'd5);
        total++; if (LEDS !== 3'b001) $display("FAIL abort_pre_leds got=%b want=001", LEDS); else passed++;
        create = 1'b1;
        @(negedge CLK);
        total++; if ({LEDS, open, nope, fail_cnt} !== 7'b0000001)
            $display("FAIL abort_state got=%b want=0000001", {LEDS, open, nope, fail_cnt}); else passed++;
        create = 1'b0;
        @(negedge CLK);
        D  = 3'd1;
        EN = 1'b1;
        repeat (20) @(negedge CLK);
        total++; if (LEDS !== 3'b001) $display("FAIL hold_single_press got=%b want=001", LEDS); else passed++;
        EN = 1'b0;
        press(3'd1);
        total++; if (LEDS !== 3'b011) $display("FAIL hold_second got=%b want=011", LEDS); else passed++;
        press(3'd1);
        @(negedge CLK);
        total++; if ({open, fail_cnt} !== 3'b100) $display("FAIL hold_open got=%b want=100", {open, fail_cnt}); else passed++;
    endtask

    task automatic test_reset_mid_entry;
        create = 1'b0;
        press(3'd1);
        press(3'd1);
        total++; if (LEDS !== 3'b011) $display("FAIL mid_pre_leds got=%b want=011", LEDS); else passed++;
        #2 RST_N = 1'b0;
        #1;
        total++; if ({open, nope, locked, pass_set, LEDS, fail_cnt} !== 9'd0)
            $display("FAIL mid_reset got=%b want=0", {open, nope, locked, pass_set, LEDS, fail_cnt}); else passed++;
        @(negedge CLK);
        RST_N = 1'b1;
        attempt(1'b0, 3'd1, 3'd1, 3'd1);
        total++; if ({open, nope, pass_set, fail_cnt} !== 5'b01000)
            $display("FAIL post_reset_enter got=%b want=01000", {open, nope, pass_set, fail_cnt}); else passed++;
    endtask

    initial begin
        test_reset;
        test_create;
        test_enter;
        test_lockout;
        test_guarded_create;
        test_abort_and_hold;
        test_reset_mid_entry;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
